// File: rtl/scene_seq_pkg.sv
// Shared types for the scene sequencer: FSM state encoding and per-object config record.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Config field widths here must be at least the top's ADDR_W/ANGLE_W.
package scene_seq_pkg;

    localparam int SKIP_W      = 16;
    localparam int CFG_ADDR_W  = 12;
    localparam int CFG_ANGLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAM,
        ST_SCAN,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0]  base;
        logic [CFG_ADDR_W-1:0]  count;
        logic [CFG_ANGLE_W-1:0] step;
    } obj_cfg_t;

endpackage

// File: rtl/scene_sequencer_if.sv
// Bundle of frame control, config, feeder handshake and status signals of the scene sequencer.
// Latency: n/a (wires only). Macro SCENE_SEQ_WATCHDOG_EN adds err_timeout.
// Backpressure: feeder_busy / renderer_busy are level inputs; nothing is queued.
interface scene_sequencer_if #(
    parameter int N_OBJ   = 4,
    parameter int ADDR_W  = 12,
    parameter int ANGLE_W = 8
);
    import scene_seq_pkg::*;

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic               frame_start;
    logic               renderer_busy;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [ADDR_W-1:0]  cfg_base;
    logic [ADDR_W-1:0]  cfg_count;
    logic [ANGLE_W-1:0] cfg_step;
    logic               feeder_busy;

    logic               cam_valid;
    logic               feeder_begin;
    logic [ADDR_W-1:0]  feeder_base;
    logic [ADDR_W-1:0]  feeder_count;
    logic [IDX_W-1:0]   obj_idx;
    logic [ANGLE_W-1:0] ang_x;
    logic [ANGLE_W-1:0] ang_y;
    logic [ANGLE_W-1:0] ang_z;
    logic               frame_done;
    logic               frame_skipped;
    logic [SKIP_W-1:0]  skip_count;
    logic               busy;
`ifdef SCENE_SEQ_WATCHDOG_EN
    logic               err_timeout;
`endif

    // Sequencer side
    modport master (
        input  frame_start, renderer_busy, cfg_we, cfg_idx, cfg_base, cfg_count, cfg_step,
        input  feeder_busy,
`ifdef SCENE_SEQ_WATCHDOG_EN
        output err_timeout,
`endif
        output cam_valid, feeder_begin, feeder_base, feeder_count, obj_idx,
        output ang_x, ang_y, ang_z, frame_done, frame_skipped, skip_count, busy
    );

    // Frame source / config host / feeder side
    modport slave (
        output frame_start, renderer_busy, cfg_we, cfg_idx, cfg_base, cfg_count, cfg_step,
        output feeder_busy,
`ifdef SCENE_SEQ_WATCHDOG_EN
        input  err_timeout,
`endif
        input  cam_valid, feeder_begin, feeder_base, feeder_count, obj_idx,
        input  ang_x, ang_y, ang_z, frame_done, frame_skipped, skip_count, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static asynchronous inputs, per bit.
// Latency: 2 clk_render cycles.
// Backpressure: none; bits are resynchronised independently (no bus coherency).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_render,
    input  logic         rst_render,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability filter chain
    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/scene_sequencer.sv
// Per-frame scene scheduler: camera pulse, then one feeder launch per enabled object, in index order.
// Latency: cam_valid at accept+1, first launch at accept+3; SCAN finds the next enabled slot in one cycle.
// Backpressure: frame_start while busy or renderer_busy is dropped and counted; optional watchdog via SCENE_SEQ_WATCHDOG_EN.
module scene_sequencer
    import scene_seq_pkg::*;
#(
    parameter int N_OBJ      = 4,
    parameter int ADDR_W     = CFG_ADDR_W,
    parameter int ANGLE_W    = CFG_ANGLE_W,
    parameter int INIT_ANG_X = 10
`ifdef SCENE_SEQ_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES = 2000000
`endif
) (
    input  logic               clk_render,
    input  logic               rst_render,
    input  logic [2:0]         rot_en,
    scene_sequencer_if.master  bus
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int PTR_W = IDX_W + 1;

    logic [2:0]         rot_sync;
    seq_state_t         state_q;
    obj_cfg_t           cfg_q [N_OBJ];
    logic [ANGLE_W-1:0] ang_q [N_OBJ][3];
    logic [ANGLE_W-1:0] ang_d [N_OBJ][3];
    logic [PTR_W-1:0]   next_q;

    logic               cam_valid_q;
    logic               feeder_begin_q;
    logic               frame_done_q;
    logic               frame_skipped_q;
    logic [ADDR_W-1:0]  feeder_base_q;
    logic [ADDR_W-1:0]  feeder_count_q;
    logic [IDX_W-1:0]   obj_idx_q;
    logic [ANGLE_W-1:0] ang_x_q;
    logic [ANGLE_W-1:0] ang_y_q;
    logic [ANGLE_W-1:0] ang_z_q;
    logic [SKIP_W-1:0]  skip_count_q;
    logic [SKIP_W-1:0]  skip_count_d;

    logic               accept;
    logic               drop;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;

`ifdef SCENE_SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0]   wdt_q;
    logic               err_timeout_q;
`endif

    sync_2ff #(.W(3)) u_rot_sync (
        .clk_render (clk_render),
        .rst_render (rst_render),
        .d_i        (rot_en),
        .q_o        (rot_sync)
    );

    assign accept = bus.frame_start && (state_q == ST_IDLE) && !bus.renderer_busy;
    assign drop   = bus.frame_start && !accept;

    // Lowest-index enabled slot at or after the scan pointer
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if ((PTR_W'(i) >= next_q) && (cfg_q[i].count != '0)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Next angles (advanced only on the accept cycle) and saturating drop count
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            for (int a = 0; a < 3; a++) begin
                ang_d[i][a] = ang_q[i][a];
                if (accept && rot_sync[a]) begin
                    ang_d[i][a] = ang_q[i][a] + ANGLE_W'(cfg_q[i].step);
                end
            end
        end
        skip_count_d = skip_count_q;
        if (drop && (skip_count_q != '1)) begin
            skip_count_d = skip_count_q + SKIP_W'(1);
        end
    end

    // Config table; writes land at any time, a running launch keeps its registered copy
    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            for (int i = 0; i < N_OBJ; i++) begin
                cfg_q[i].base  <= '0;
                cfg_q[i].count <= '0;
                cfg_q[i].step  <= CFG_ANGLE_W'(1);
            end
        end else if (bus.cfg_we && (int'(bus.cfg_idx) < N_OBJ)) begin
            cfg_q[bus.cfg_idx].base  <= CFG_ADDR_W'(bus.cfg_base);
            cfg_q[bus.cfg_idx].count <= CFG_ADDR_W'(bus.cfg_count);
            cfg_q[bus.cfg_idx].step  <= CFG_ANGLE_W'(bus.cfg_step);
        end
    end

    // Per-object angle table
    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            for (int i = 0; i < N_OBJ; i++) begin
                ang_q[i][0] <= ANGLE_W'(INIT_ANG_X);
                ang_q[i][1] <= '0;
                ang_q[i][2] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                for (int a = 0; a < 3; a++) begin
                    ang_q[i][a] <= ang_d[i][a];
                end
            end
        end
    end

    // Frame FSM with registered pulse and launch-descriptor outputs
    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            state_q         <= ST_IDLE;
            next_q          <= '0;
            cam_valid_q     <= 1'b0;
            feeder_begin_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_skipped_q <= 1'b0;
            feeder_base_q   <= '0;
            feeder_count_q  <= '0;
            obj_idx_q       <= '0;
            ang_x_q         <= ANGLE_W'(INIT_ANG_X);
            ang_y_q         <= '0;
            ang_z_q         <= '0;
            skip_count_q    <= '0;
`ifdef SCENE_SEQ_WATCHDOG_EN
            wdt_q           <= '0;
            err_timeout_q   <= 1'b0;
`endif
        end else begin
            cam_valid_q     <= 1'b0;
            feeder_begin_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_skipped_q <= drop;
            skip_count_q    <= skip_count_d;
`ifdef SCENE_SEQ_WATCHDOG_EN
            err_timeout_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_CAM;
                        cam_valid_q <= 1'b1;
                        next_q      <= '0;
                    end
                end
                ST_CAM: state_q <= ST_SCAN;
                ST_SCAN: begin
                    if (hit) begin
                        state_q        <= ST_LAUNCH;
                        feeder_begin_q <= 1'b1;
                        obj_idx_q      <= hit_idx;
                        feeder_base_q  <= ADDR_W'(cfg_q[hit_idx].base);
                        feeder_count_q <= ADDR_W'(cfg_q[hit_idx].count);
                        ang_x_q        <= ang_q[hit_idx][0];
                        ang_y_q        <= ang_q[hit_idx][1];
                        ang_z_q        <= ang_q[hit_idx][2];
                        next_q         <= PTR_W'(hit_idx) + PTR_W'(1);
`ifdef SCENE_SEQ_WATCHDOG_EN
                        wdt_q          <= '0;
`endif
                    end else begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_LAUNCH: state_q <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (bus.feeder_busy) begin
                        state_q <= ST_WAIT_LO;
`ifdef SCENE_SEQ_WATCHDOG_EN
                        wdt_q   <= wdt_q + WDT_W'(1);
                    end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                        state_q       <= ST_SCAN;
                        err_timeout_q <= 1'b1;
                    end else begin
                        wdt_q <= wdt_q + WDT_W'(1);
`endif
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.feeder_busy) begin
                        state_q <= ST_SCAN;
`ifdef SCENE_SEQ_WATCHDOG_EN
                    end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                        state_q       <= ST_SCAN;
                        err_timeout_q <= 1'b1;
                    end else begin
                        wdt_q <= wdt_q + WDT_W'(1);
`endif
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cam_valid     = cam_valid_q;
    assign bus.feeder_begin  = feeder_begin_q;
    assign bus.feeder_base   = feeder_base_q;
    assign bus.feeder_count  = feeder_count_q;
    assign bus.obj_idx       = obj_idx_q;
    assign bus.ang_x         = ang_x_q;
    assign bus.ang_y         = ang_y_q;
    assign bus.ang_z         = ang_z_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_skipped = frame_skipped_q;
    assign bus.skip_count    = skip_count_q;
    assign bus.busy          = (state_q != ST_IDLE);
`ifdef SCENE_SEQ_WATCHDOG_EN
    assign bus.err_timeout   = err_timeout_q;
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: directed frames, angle vector table, drop and reset corners.
// Latency expectations are hand-derived cycle offsets from the frame accept edge.
// Backpressure: a behavioural feeder holds feeder_busy for feeder_len cycles per launch (or never, when dead).
module tb_scene_sequencer;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int GW = 8;
    localparam int IW = 2;

    logic       clk_render = 1'b0;
    logic       rst_render = 1'b1;
    logic [2:0] rot_en     = 3'b000;

    scene_sequencer_if #(.N_OBJ(N), .ADDR_W(AW), .ANGLE_W(GW)) bus ();

    scene_sequencer #(
        .N_OBJ(N), .ADDR_W(AW), .ANGLE_W(GW), .INIT_ANG_X(10)
`ifdef SCENE_SEQ_WATCHDOG_EN
        , .WDT_CYCLES(50)
`endif
    ) dut (
        .clk_render (clk_render),
        .rst_render (rst_render),
        .rot_en     (rot_en),
        .bus        (bus.master)
    );

    always #5 clk_render = ~clk_render;

    int cyc = 0;
    always @(posedge clk_render) cyc <= cyc + 1;

    // Behavioural triangle feeder
    logic fb_busy     = 1'b0;
    int   fb_cnt      = 0;
    int   feeder_len  = 20;
    bit   feeder_dead = 1'b0;
    assign bus.feeder_busy = fb_busy;

    always @(posedge clk_render) begin
        #2;
        if (rst_render) begin
            fb_cnt  = 0;
            fb_busy = 1'b0;
        end else if (fb_cnt > 0) begin
            fb_cnt--;
            if (fb_cnt == 0) fb_busy = 1'b0;
        end else if (bus.feeder_begin === 1'b1 && !feeder_dead) begin
            fb_busy = 1'b1;
            fb_cnt  = feeder_len;
        end
    end

    // Output event monitor
    typedef struct {
        int cyc; int base; int cnt; int idx; int ax; int ay; int az;
    } launch_t;
    launch_t launches[$];
    int cam_n = 0, cam_cyc = -1, done_n = 0, done_cyc = -1, skip_n = 0, skip_cyc = -1;
    int err_n = 0, err_cyc = -1;

    always @(negedge clk_render) begin
        if (bus.cam_valid === 1'b1)     begin cam_n++;  cam_cyc  = cyc; end
        if (bus.frame_done === 1'b1)    begin done_n++; done_cyc = cyc; end
        if (bus.frame_skipped === 1'b1) begin skip_n++; skip_cyc = cyc; end
`ifdef SCENE_SEQ_WATCHDOG_EN
        if (bus.err_timeout === 1'b1)   begin err_n++;  err_cyc  = cyc; end
`endif
        if (bus.feeder_begin === 1'b1)
            launches.push_back('{cyc, int'(bus.feeder_base), int'(bus.feeder_count),
                                 int'(bus.obj_idx), int'(bus.ang_x), int'(bus.ang_y), int'(bus.ang_z)});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input int base, input int cnt, input int step);
        @(negedge clk_render);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = IW'(idx);
        bus.cfg_base  = AW'(base);
        bus.cfg_count = AW'(cnt);
        bus.cfg_step  = GW'(step);
        @(posedge clk_render);
        #1;
        bus.cfg_we    = 1'b0;
    endtask

    // Returns the number of the clock edge that samples the pulse
    task automatic pulse_frame(output int p);
        @(negedge clk_render);
        p = cyc + 1;
        bus.frame_start = 1'b1;
        @(posedge clk_render);
        #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk_render);
            n++;
        end
        #1;
        check(name, int'(bus.busy), 0);
    endtask

    task automatic check_launch(input string tag, input int k, input int idx, input int base,
                                input int cnt, input int ax, input int ay, input int az);
        if (k < launches.size()) begin
            check({tag, "_idx"},  launches[k].idx,  idx);
            check({tag, "_base"}, launches[k].base, base);
            check({tag, "_cnt"},  launches[k].cnt,  cnt);
            check({tag, "_angx"}, launches[k].ax,   ax);
            check({tag, "_angy"}, launches[k].ay,   ay);
            check({tag, "_angz"}, launches[k].az,   az);
        end else begin
            check({tag, "_present"}, launches.size(), k + 1);
        end
    endtask

    typedef struct {
        logic [2:0] rot; int step; int ex; int ey; int ez;
    } ang_vec_t;
    ang_vec_t av[9];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1);
    end

    initial begin
        int p, p2, p3, n0, c0, s0, d0, e0;

        // Slot-0 angle sequence: {rot_en, step, expected x, y, z at launch}
        av[0] = '{3'b001,   2, 12,   0,   0};
        av[1] = '{3'b001,   2, 14,   0,   0};
        av[2] = '{3'b001,   2, 16,   0,   0};
        av[3] = '{3'b000,   2, 16,   0,   0};
        av[4] = '{3'b010, 255, 16, 255,   0};
        av[5] = '{3'b010,   1, 16,   0,   0};
        av[6] = '{3'b111,   3, 19,   3,   3};
        av[7] = '{3'b100, 250, 19,   3, 253};
        av[8] = '{3'b100,   5, 19,   3,   2};

        bus.frame_start   = 1'b0;
        bus.renderer_busy = 1'b0;
        bus.cfg_we        = 1'b0;
        bus.cfg_idx       = '0;
        bus.cfg_base      = '0;
        bus.cfg_count     = '0;
        bus.cfg_step      = '0;

        // Reset state
        repeat (3) @(negedge clk_render);
        check("rst_busy",      int'(bus.busy), 0);
        check("rst_cam",       int'(bus.cam_valid), 0);
        check("rst_begin",     int'(bus.feeder_begin), 0);
        check("rst_done",      int'(bus.frame_done), 0);
        check("rst_skipped",   int'(bus.frame_skipped), 0);
        check("rst_obj_idx",   int'(bus.obj_idx), 0);
        check("rst_skipcount", int'(bus.skip_count), 0);
        check("rst_ang_x",     int'(bus.ang_x), 10);
        check("rst_ang_y",     int'(bus.ang_y), 0);
        check("rst_ang_z",     int'(bus.ang_z), 0);
        rst_render = 1'b0;
        repeat (3) @(negedge clk_render);

        // Two enabled slots (0 and 2), 20-cycle feeder
        cfg_write(0, 0, 10, 1);
        cfg_write(2, 10, 5, 1);
        feeder_len = 20;
        n0 = launches.size(); c0 = cam_n; d0 = done_n;
        pulse_frame(p);
        wait_idle("main_idle", 200);
        check("main_cam_n",   cam_n - c0, 1);
        check("main_cam_cyc", cam_cyc, p);
        check("main_launches", launches.size() - n0, 2);
        check_launch("main_l0", n0, 0, 0, 10, 10, 0, 0);
        check_launch("main_l1", n0 + 1, 2, 10, 5, 10, 0, 0);
        if (launches.size() >= n0 + 2) begin
            check("main_l0_cyc", launches[n0].cyc, p + 2);
            check("main_l1_cyc", launches[n0 + 1].cyc, p + 24);
        end
        check("main_done_n",   done_n - d0, 1);
        check("main_done_cyc", done_cyc, p + 46);

        // Drop during WAIT_LO, then drop because renderer is busy
        c0 = cam_n; s0 = skip_n;
        pulse_frame(p);
        repeat (8) @(negedge clk_render);
        pulse_frame(p2);
        @(negedge clk_render); #1;
        check("skip_wait_cyc", skip_cyc, p2);
        wait_idle("skip_idle", 200);
        bus.renderer_busy = 1'b1;
        pulse_frame(p3);
        @(negedge clk_render); #1;
        check("skip_rbusy_cyc",  skip_cyc, p3);
        check("skip_rbusy_idle", int'(bus.busy), 0);
        bus.renderer_busy = 1'b0;
        check("skip_pulses", skip_n - s0, 2);
        check("skip_count",  int'(bus.skip_count), 2);
        check("skip_cam_n",  cam_n - c0, 1);

        // All slots disabled
        cfg_write(0, 0, 0, 1);
        cfg_write(2, 0, 0, 1);
        n0 = launches.size(); c0 = cam_n; d0 = done_n;
        pulse_frame(p);
        wait_idle("empty_idle", 50);
        check("empty_cam_cyc",  cam_cyc, p);
        check("empty_launches", launches.size() - n0, 0);
        check("empty_done_n",   done_n - d0, 1);
        check("empty_done_cyc", done_cyc, p + 2);

        // Angle vector table on slot 0
        feeder_len = 3;
        for (int i = 0; i < 9; i++) begin
            rot_en = av[i].rot;
            cfg_write(0, 7, 1, av[i].step);
            repeat (3) @(negedge clk_render);
            n0 = launches.size();
            pulse_frame(p);
            wait_idle($sformatf("ang%0d_idle", i), 100);
            check($sformatf("ang%0d_launches", i), launches.size() - n0, 1);
            check_launch($sformatf("ang%0d", i), n0, 0, 7, 1, av[i].ex, av[i].ey, av[i].ez);
        end
        cfg_write(0, 0, 0, 1);

        // Reset while the feeder never answers (FSM parked in WAIT_HI)
        cfg_write(1, 5, 3, 7);
        rot_en = 3'b111;
        repeat (3) @(negedge clk_render);
        feeder_dead = 1'b1;
        n0 = launches.size();
        pulse_frame(p);
        repeat (6) @(negedge clk_render); #1;
        check("mid_launches", launches.size() - n0, 1);
        check_launch("mid_l0", n0, 1, 5, 3, 21, 10, 10);
        check("mid_busy", int'(bus.busy), 1);
        rst_render = 1'b1;
        #1;
        check("mid_rst_busy",   int'(bus.busy), 0);
        check("mid_rst_ang_x",  int'(bus.ang_x), 10);
        check("mid_rst_ang_y",  int'(bus.ang_y), 0);
        check("mid_rst_ang_z",  int'(bus.ang_z), 0);
        check("mid_rst_idx",    int'(bus.obj_idx), 0);
        check("mid_rst_skip",   int'(bus.skip_count), 0);
        check("mid_rst_fcount", int'(bus.feeder_count), 0);
        repeat (2) @(negedge clk_render);
        rst_render  = 1'b0;
        feeder_dead = 1'b0;

        // Config counts back to 0, angles and default step 1 restored
        rot_en = 3'b001;
        repeat (3) @(negedge clk_render);
        n0 = launches.size();
        pulse_frame(p);
        wait_idle("post_rst_idle", 50);
        check("post_rst_launches", launches.size() - n0, 0);
        check("post_rst_done_cyc", done_cyc, p + 2);
        cfg_write(1, 5, 3, 4);
        n0 = launches.size();
        pulse_frame(p);
        wait_idle("post_rst2_idle", 100);
        check_launch("post_rst_l0", n0, 1, 5, 3, 15, 0, 0);

`ifdef SCENE_SEQ_WATCHDOG_EN
        // Feeder never rises: abandon after the watchdog limit and finish the frame
        feeder_dead = 1'b1;
        n0 = launches.size(); e0 = err_n; d0 = done_n;
        pulse_frame(p);
        wait_idle("wdt_idle", 200);
        check("wdt_err_n",  err_n - e0, 1);
        check("wdt_done_n", done_n - d0, 1);
        if (launches.size() > n0)
            check("wdt_err_delay", err_cyc - launches[n0].cyc, 51);
        else
            check("wdt_launch_present", launches.size() - n0, 1);
        feeder_dead = 1'b0;
`else
        e0 = err_n;
`endif

        repeat (2) @(negedge clk_render);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
